instruction_fetch_unit: RTL and testbench

//  Fetch-side initiator for the 128-word instruction memory. It owns the PC, drives the word

---
 rtl/ifu_pkg.sv | 19 +
 rtl/instruction_fetch_unit_if.sv | 24 ++
 rtl/fetch_queue.sv | 58 +++++
 rtl/instruction_fetch_unit.sv | 106 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: FSM states, word/PC constants and
// the fetch-queue entry pairing an instruction with the byte address it came from.
package ifu_pkg;

   localparam int          INSTR_W = 32;
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_FULL  = 2'd2
   } ifu_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [INSTR_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect from execute, decode handshake.
// master = fetch unit side, slave = memory/execute/decode side.
interface instruction_fetch_unit_if;

   logic [ifu_pkg::INSTR_W-1:0] ImemAddress;
   logic [ifu_pkg::INSTR_W-1:0] ImemInstruction;
   logic                        Redirect;
   logic [ifu_pkg::INSTR_W-1:0] RedirectTarget;
   logic                        InstrValid;
   logic                        InstrReady;
   logic [ifu_pkg::INSTR_W-1:0] Instruction;
   logic [ifu_pkg::INSTR_W-1:0] InstrPC;

   modport master (
      output ImemAddress, InstrValid, Instruction, InstrPC,
      input  ImemInstruction, Redirect, RedirectTarget, InstrReady
   );

   modport slave (
      input  ImemAddress, InstrValid, Instruction, InstrPC,
      output ImemInstruction, Redirect, RedirectTarget, InstrReady
   );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {instr, pc}; push visible at the head one cycle later, flush wins.
// The head is read from registered storage; when empty it holds the last head shown.
module fetch_queue
   import ifu_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW  = $clog2(DEPTH),
   localparam int CW  = AW + 1
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         i_push,
   input  fetch_entry_t i_push_dat,
   input  logic         i_pop,
   input  logic         i_flush,
   output fetch_entry_t o_head_dat,
   output logic [CW-1:0] o_count
);

   fetch_entry_t  r_mem [DEPTH];
   fetch_entry_t  r_hold;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_hold   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // Snapshot the visible head so the outputs freeze once the queue drains.
         if (r_count != '0) r_hold <= r_mem[r_rd_ptr];
         if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (i_push) begin
               r_mem[r_wr_ptr] <= i_push_dat;
               r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   assign o_head_dat = (r_count != '0) ? r_mem[r_rd_ptr] : r_hold;
   assign o_count    = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC owner and fetch initiator: one word per cycle into fetch_queue, head valid 1 cycle after fetch.
// Stops fetching when the queue is full and decode stalls; Redirect flushes. Option: IFU_FETCH_STATS_EN.
module instruction_fetch_unit
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   instruction_fetch_unit_if.master bus
`ifdef IFU_FETCH_STATS_EN
   ,
   output logic [31:0]              FetchCount,
   output logic [31:0]              StallCount
`endif
);

   localparam int          QCW      = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [31:0] W_RST_PC = {RESET_PC[31:2], 2'b00};

   ifu_state_t   r_state;
   ifu_state_t   w_state_nxt;
   logic [31:0]  r_pc;
   logic [31:0]  w_target;
   logic [QCW-1:0] w_count;
   logic         w_full;
   logic         w_empty;
   logic         w_fetch_en;
   logic         w_push;
   logic         w_pop;
   fetch_entry_t w_push_dat;
   fetch_entry_t w_head;

   assign w_target   = bus.RedirectTarget & 32'hFFFF_FFFC;
   assign w_full     = (w_count == QCW'(QUEUE_DEPTH));
   assign w_empty    = (w_count == '0);
   assign w_fetch_en = !w_full || bus.InstrReady;
   assign w_pop      = !w_empty && bus.InstrReady && !bus.Redirect;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) r_state <= S_BOOT;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.Redirect) begin
         w_state_nxt = S_FETCH;
      end else begin
         case (r_state)
            S_BOOT:  w_state_nxt = S_FETCH;
            S_FETCH: if (!w_fetch_en) w_state_nxt = S_FULL;
            S_FULL:  if (w_pop) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_BOOT;
         endcase
      end
   end

   // A full queue with decode ready still fetches: the pop frees the slot on the same edge.
   always_comb begin
      w_push = 1'b0;
      case (r_state)
         S_FETCH, S_FULL: w_push = w_fetch_en && !bus.Redirect;
         default:         w_push = 1'b0;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)          r_pc <= W_RST_PC;
      else if (bus.Redirect) r_pc <= w_target;
      else if (w_push)       r_pc <= r_pc + PC_STEP;
   end

   assign w_push_dat.instr = bus.ImemInstruction;
   assign w_push_dat.pc    = r_pc;

   fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_fetch_queue (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .i_flush    (bus.Redirect),
      .o_head_dat (w_head),
      .o_count    (w_count)
   );

   assign bus.ImemAddress = r_pc;
   assign bus.InstrValid  = !w_empty;
   assign bus.Instruction = w_head.instr;
   assign bus.InstrPC     = w_head.pc;

`ifdef IFU_FETCH_STATS_EN
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         FetchCount <= '0;
         StallCount <= '0;
      end else begin
         if (w_push)            FetchCount <= FetchCount + 32'd1;
         if (r_state == S_FULL) StallCount <= StallCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios then random ready/redirect traffic,
// each cycle compared against a queue-based reference model.
module tb_instruction_fetch_unit;
   import ifu_pkg::*;

   localparam int DEPTH = 2;

   logic Clk = 1'b0;
   logic Reset_n;
   always #5 Clk = ~Clk;

   instruction_fetch_unit_if ifc ();

   logic [31:0] mem [128];
   assign ifc.ImemInstruction = mem[ifc.ImemAddress[8:2]];

`ifdef IFU_FETCH_STATS_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   instruction_fetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH(DEPTH)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (ifc)
`ifdef IFU_FETCH_STATS_EN
      ,
      .FetchCount (fetch_count),
      .StallCount (stall_count)
`endif
   );

   // Reference model state
   fetch_entry_t mq[$];
   logic [31:0]  mpc;
   bit           mboot;
   bit           mfull;
   fetch_entry_t last;
   logic [31:0]  m_fetch;
   logic [31:0]  m_stall;
   int           n_pass;
   int           n_total;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      mpc     = 32'h0;
      mboot   = 1'b1;
      mfull   = 1'b0;
      last    = '0;
      m_fetch = 32'h0;
      m_stall = 32'h0;
   endtask

   // Applies the fetch rules for one rising edge using the inputs held across it.
   task automatic model_edge();
      bit fe, pop, push;
      fetch_entry_t e;
      if (mfull) m_stall++;
      if (ifc.Redirect) begin
         mq.delete();
         mpc   = ifc.RedirectTarget & 32'hFFFF_FFFC;
         mfull = 1'b0;
      end else begin
         fe   = (mq.size() < DEPTH) || ifc.InstrReady;
         pop  = (mq.size() > 0) && ifc.InstrReady;
         push = !mboot && fe;
         if (!mboot) mfull = mfull ? !pop : !fe;
         if (pop) void'(mq.pop_front());
         if (push) begin
            e.instr = mem[mpc[8:2]];
            e.pc    = mpc;
            mq.push_back(e);
            mpc = mpc + 32'd4;
            m_fetch++;
         end
      end
      mboot = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_addr"}, ifc.ImemAddress, mpc);
      chk({tag, "_valid"}, 32'(ifc.InstrValid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk({tag, "_instr"}, ifc.Instruction, mq[0].instr);
         chk({tag, "_pc"}, ifc.InstrPC, mq[0].pc);
         last = mq[0];
      end else begin
         chk({tag, "_hold_instr"}, ifc.Instruction, last.instr);
         chk({tag, "_hold_pc"}, ifc.InstrPC, last.pc);
      end
`ifdef IFU_FETCH_STATS_EN
      chk({tag, "_fetchcnt"}, fetch_count, m_fetch);
      chk({tag, "_stallcnt"}, stall_count, m_stall);
`endif
   endtask

   task automatic step(input string tag);
      @(posedge Clk);
      model_edge();
      #1;
      check_outputs(tag);
   endtask

   // Asserts reset between edges, checks the immediate effect, releases on the falling edge.
   task automatic do_reset(input string tag);
      Reset_n = 1'b0;
      #1;
      model_reset();
      check_outputs(tag);
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      for (int i = 0; i < 128; i++) mem[i] = 32'(i * 4);
      ifc.Redirect       = 1'b0;
      ifc.RedirectTarget = 32'h0;
      ifc.InstrReady     = 1'b0;
      Reset_n            = 1'b1;
      #2;

      // 1: streaming from reset
      do_reset("t1_rst");
      ifc.InstrReady = 1'b1;
      step("t1_boot");
      step("t1_first");
      chk("t1_first_valid", 32'(ifc.InstrValid), 32'd1);
      chk("t1_first_pc", ifc.InstrPC, 32'h0);
      step("t1_s2");
      chk("t1_second_instr", ifc.Instruction, 32'h4);
      for (int i = 0; i < 4; i++) step("t1_run");

      // 2: decode stall fills the queue, then resumes without gap
      do_reset("t2_rst");
      ifc.InstrReady = 1'b0;
      for (int i = 0; i < 5; i++) step("t2_stall");
      chk("t2_stop_pc", ifc.ImemAddress, 32'h8);
      ifc.InstrReady = 1'b1;
      step("t2_rel0");
      step("t2_rel1");
      chk("t2_head_after_pops", ifc.InstrPC, 32'h8);
      step("t2_rel2");

      // 3: redirect while full
      ifc.InstrReady = 1'b0;
      for (int i = 0; i < 3; i++) step("t3_fill");
      ifc.Redirect       = 1'b1;
      ifc.RedirectTarget = 32'h40;
      step("t3_redir");
      chk("t3_valid_low", 32'(ifc.InstrValid), 32'd0);
      chk("t3_addr", ifc.ImemAddress, 32'h40);
      ifc.Redirect = 1'b0;
      step("t3_after");
      chk("t3_instr", ifc.Instruction, 32'h40);
      chk("t3_pc", ifc.InstrPC, 32'h40);

      // 4: redirect and ready together while full, unaligned target
      for (int i = 0; i < 3; i++) step("t4_fill");
      ifc.Redirect       = 1'b1;
      ifc.RedirectTarget = 32'h43;
      ifc.InstrReady     = 1'b1;
      step("t4_redir");
      chk("t4_valid_low", 32'(ifc.InstrValid), 32'd0);
      chk("t4_addr", ifc.ImemAddress, 32'h40);
      ifc.Redirect = 1'b0;
      step("t4_after");
      chk("t4_pc", ifc.InstrPC, 32'h40);

      // 5: PC wraps at the top of the address space
      ifc.Redirect       = 1'b1;
      ifc.RedirectTarget = 32'hFFFF_FFFC;
      step("t5_redir");
      ifc.Redirect = 1'b0;
      step("t5_w0");
      chk("t5_pc0", ifc.InstrPC, 32'hFFFF_FFFC);
      step("t5_w1");
      chk("t5_pc1", ifc.InstrPC, 32'h0);
      step("t5_w2");
      chk("t5_pc2", ifc.InstrPC, 32'h4);

      // 6: asynchronous reset mid-stream
      step("t6_run");
      do_reset("t6_rst");
      chk("t6_valid_now", 32'(ifc.InstrValid), 32'd0);
      step("t6_boot");
      step("t6_first");

      // Random traffic against randomized memory contents
      for (int i = 0; i < 128; i++) mem[i] = $urandom;
      do_reset("rnd_rst");
      for (int i = 0; i < 400; i++) begin
         ifc.InstrReady     = ($urandom_range(0, 9) < 7);
         ifc.Redirect       = ($urandom_range(0, 19) == 0);
         ifc.RedirectTarget = $urandom;
         step("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
